ars_subshift_rows: RTL
======================

Name: ars_subshift_rows

Overview:
- AES round stage sitting directly upstream of the column-mix stage: applies SubBytes then ShiftRows (encrypt), or InvSubBytes then InvShiftRows (decrypt), to one 128-bit state.
- Iterative: SBOX_LANES S-box instances are reused over several cycles to save area.
- Result and single-cycle ready_o pulse feed the column-mix stage's data_i/start_i directly.

Parameters:
- SBOX_LANES, 4, bytes substituted per cycle; legal values 4, 8, 16. Other values are an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- decrypt_i  input  1  0 = forward SubBytes/ShiftRows, 1 = inverse; sampled only with start_i
- start_i  input  1  start request; accepted only in IDLE
- data_i  input  128  state in, column-major: byte0 = [127:120], column c = bytes 4c..4c+3, row r = byte index mod 4
- ready_o  output  1  one-cycle pulse when data_o is updated
- data_o  output  128  transformed state; holds until the next completion

Behaviour:
- Reset (reset low, asynchronous): state = IDLE, counter = 0, work register = 0, mode = 0, ready_o = 0, data_o = 0.
- N = 16/SBOX_LANES cycles per block: 4, 2 or 1.
- IDLE:
  - start_i high at a rising edge: capture data_i into the work register and decrypt_i into the mode register.
  - Counter cleared; go to BUSY.
  - start_i low: stay in IDLE.
- BUSY, each edge:
  - Substitute byte group k (k = counter) with the forward or inverse S-box per the mode register. Group k covers bytes k*SBOX_LANES .. k*SBOX_LANES+SBOX_LANES-1, MSB first.
  - Write the group back into the work register and increment the counter.
- On the edge processing group N-1:
  - data_o <= ShiftRows(work register with the final group substituted).
  - ready_o <= 1 for exactly one cycle; go to IDLE.
- Latency: ready_o and the new data_o are visible N edges after the start edge (4 for the default).
- ShiftRows mapping, encrypt: out(r,c) = in(r,(c+r) mod 4).
- InvShiftRows mapping, decrypt: out(r,c) = in(r,(c-r) mod 4).
- Order of SubBytes and ShiftRows is irrelevant to the result; the substitution happens in the work register and the permutation on the path into data_o.
- Throughput: a new start_i is accepted in the cycle ready_o is high, since the state is already IDLE. Back-to-back blocks therefore run every N+1 cycles.
- start_i while BUSY: ignored; no queuing, no effect on the current block.
- decrypt_i and data_i changes while BUSY: no effect.
- ready_o low in every cycle other than the completion pulse.
- data_o changes only on completion or reset.
- Reset mid-operation: the block is discarded, outputs go to reset values immediately, and no ready_o pulse is issued.
- S-boxes: constant 256-entry forward and inverse tables per FIPS-197, instantiated combinationally, SBOX_LANES of each.

Optional Feature:
- Macro ARS_SUBSHIFT_ABORT_EN defined:
  - Adds input abort_i (1 bit).
  - abort_i high at an edge while BUSY: return to IDLE, clear the counter, leave data_o unchanged, no ready_o pulse.
  - abort_i and start_i both high in IDLE: abort_i wins and the start is not accepted.
- Macro undefined: no abort_i port; a block, once started, always completes.

Test Plan:
- Reset, then encrypt data_i = 193de3bea0f4e22b9ac68d2ae9f84808 -> after 4 edges ready_o pulses once with data_o = d4bf5d30e0b452aeb84111f11e2798e5 (FIPS-197 App. B, round 1).
- Decrypt data_i = d4bf5d30e0b452aeb84111f11e2798e5 -> data_o = 193de3bea0f4e22b9ac68d2ae9f84808.
- All-zero encrypt -> data_o = 63 repeated ×16. All-zero decrypt -> 52 repeated ×16.
- start_i held high continuously with alternating inputs -> ready_o pulses every 5 cycles. start_i pulses issued while BUSY are ignored, and data_o matches only the accepted blocks.
- Drop reset at cycle 2 of BUSY -> ready_o = 0 and data_o = 0 at once. After release, a fresh block completes normally in 4 edges.
- With ARS_SUBSHIFT_ABORT_EN defined: abort_i at cycle 2 of BUSY -> no ready_o pulse and data_o keeps its previous value. Repeat the regression with SBOX_LANES = 8 and 16 (latency 2 and 1).

Source files
------------

// File: rtl/ars_subshift_rows.sv
// Iterative AES SubBytes+ShiftRows stage (and its inverse) feeding the column-mix stage.
// Optional abort input is enabled by defining ARS_SUBSHIFT_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start_i; data_o holds the last result
// BUSY  | substituting SBOX_LANES bytes per edge until the last group is done
module ars_subshift_rows #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
`ifdef ARS_SUBSHIFT_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         decrypt_i,
  input  logic         start_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic [127:0] data_o
);

  localparam int N = 16 / SBOX_LANES;
  localparam logic [1:0] LAST = 2'(N - 1);

  generate
    if (SBOX_LANES != 4 && SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
      $error("ars_subshift_rows: SBOX_LANES must be 4, 8 or 16");
    end
  endgenerate

  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX_FWD[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return SBOX_INV[8*(255 - int'(x)) +: 8];
  endfunction

  // Byte (r,c) lives at index 4c+r, MSB first; inv selects the decrypt rotation.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[8*(15 - (4*c + r)) +: 8] = s[8*(15 - (4*src + r)) +: 8];
      end
    end
    return o;
  endfunction

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [1:0]    cnt;
  logic [127:0]  work, work_sub;
  logic          mode;
  logic          abort;
  logic          accept;
  logic          last;
  int            grp_base;
  logic [7:0]    lane_in  [SBOX_LANES];
  logic [7:0]    lane_fwd [SBOX_LANES];
  logic [7:0]    lane_inv [SBOX_LANES];

`ifdef ARS_SUBSHIFT_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign accept   = (state == IDLE) && start_i && !abort;
  assign last     = (cnt == LAST);
  assign grp_base = int'(cnt) * SBOX_LANES;

  generate
    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
      assign lane_in[j]  = work[8*(15 - (grp_base + j)) +: 8];
      assign lane_fwd[j] = sbox_fwd(lane_in[j]);
      assign lane_inv[j] = sbox_inv(lane_in[j]);
    end
  endgenerate

  always_comb begin
    work_sub = work;
    for (int j = 0; j < SBOX_LANES; j++) begin
      work_sub[8*(15 - (grp_base + j)) +: 8] = mode ? lane_inv[j] : lane_fwd[j];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (accept) state_nxt = BUSY;
    end else begin
      if (abort || last) state_nxt = IDLE;
    end
  end

  // Substitution happens in place; the row permutation is applied only on the way to data_o.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 2'd0;
      work    <= '0;
      mode    <= 1'b0;
      ready_o <= 1'b0;
      data_o  <= '0;
    end else begin
      ready_o <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          work <= data_i;
          mode <= decrypt_i;
          cnt  <= 2'd0;
        end
      end else if (abort) begin
        cnt <= 2'd0;
      end else begin
        work <= work_sub;
        if (last) begin
          cnt     <= 2'd0;
          data_o  <= shift_rows(work_sub, mode);
          ready_o <= 1'b1;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

endmodule
